// File: rtl/pwm_ramp_ctrl.sv
// PWM duty-cycle ramp controller: a config slave holds PERIOD/TARGET/STEP, and
// on start a master port programs the PWM peripheral and steps the duty up to TARGET.
module pwm_ramp_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_chipselect,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        m_chipselect,
    output logic        m_write,
    output logic [1:0]  m_address,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic        busy,
    output logic        done_irq
);

    typedef enum logic [2:0] {
        IDLE,
        WR_PER,
        WR_DUTY0,
        WR_EN,
        WAIT,
        WR_STEP,
        WR_DIS
    } state_t;

    localparam logic [1:0] PWM_DIV  = 2'd0;
    localparam logic [1:0] PWM_DUTY = 2'd1;
    localparam logic [1:0] PWM_CTRL = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] target_q, target_d;
    logic [31:0] step_q, step_d;
    logic [31:0] w_period_q, w_period_d;
    logic [31:0] w_target_q, w_target_d;
    logic [15:0] w_step_q, w_step_d;
    logic [15:0] w_intv_q, w_intv_d;
    logic [31:0] cur_duty_q, cur_duty_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        m_write_q, m_write_d;
    logic [1:0]  m_address_q, m_address_d;
    logic [31:0] m_writedata_q, m_writedata_d;

    logic        slave_wr;
    logic        ctrl_wr;
    logic        start_req;
    logic        abort_req;
    logic        clear_req;
    logic [15:0] step_eff;
    logic [15:0] intv_eff;
    logic [32:0] duty_sum;
    logic [31:0] duty_next;
    logic        complete;
    logic        start_accept;

    assign slave_wr  = s_chipselect & s_write;
    assign ctrl_wr   = slave_wr && (s_address == 2'd3);
    assign start_req = ctrl_wr & s_writedata[0] & ~s_writedata[1];
    assign abort_req = ctrl_wr & s_writedata[1];
    assign clear_req = ctrl_wr & s_writedata[2];

    // Zero step or interval would stall the ramp, so both are floored at one.
    assign step_eff  = (w_step_q == 16'd0) ? 16'd1 : w_step_q;
    assign intv_eff  = (w_intv_q == 16'd0) ? 16'd1 : w_intv_q;
    assign duty_sum  = {1'b0, cur_duty_q} + {17'd0, step_eff};
    assign duty_next = (duty_sum > {1'b0, w_target_q}) ? w_target_q : duty_sum[31:0];

    // Slave register file.
    always_comb begin
        period_d = period_q;
        target_d = target_q;
        step_d   = step_q;
        if (slave_wr) begin
            case (s_address)
                2'd0:    period_d = s_writedata;
                2'd1:    target_d = s_writedata;
                2'd2:    step_d   = s_writedata;
                default: ;
            endcase
        end
    end

    always_comb begin
        s_readdata = 32'h0;
        if (s_read && s_chipselect) begin
            case (s_address)
                2'd0:    s_readdata = period_q;
                2'd1:    s_readdata = target_q;
                2'd2:    s_readdata = step_q;
                default: s_readdata = {30'd0, done_q, busy_q};
            endcase
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        w_period_d    = w_period_q;
        w_target_d    = w_target_q;
        w_step_d      = w_step_q;
        w_intv_d      = w_intv_q;
        cur_duty_d    = cur_duty_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        m_write_d     = 1'b0;
        m_address_d   = 2'd0;
        m_writedata_d = 32'd0;
        complete      = 1'b0;
        start_accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    start_accept  = 1'b1;
                    state_d       = WR_PER;
                    w_period_d    = period_q;
                    w_target_d    = target_q;
                    w_step_d      = step_q[15:0];
                    w_intv_d      = step_q[31:16];
                    cur_duty_d    = 32'd0;
                    busy_d        = 1'b1;
                    m_write_d     = 1'b1;
                    m_address_d   = PWM_DIV;
                    m_writedata_d = period_q;
                end
            end
            WR_PER: begin
                state_d       = WR_DUTY0;
                m_write_d     = 1'b1;
                m_address_d   = PWM_DUTY;
                m_writedata_d = 32'd0;
            end
            WR_DUTY0: begin
                state_d       = WR_EN;
                m_write_d     = 1'b1;
                m_address_d   = PWM_CTRL;
                m_writedata_d = 32'd1;
            end
            WR_EN, WR_STEP: begin
                if (cur_duty_q >= w_target_q) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                end else if (intv_eff == 16'd1) begin
                    state_d       = WR_STEP;
                    cur_duty_d    = duty_next;
                    m_write_d     = 1'b1;
                    m_address_d   = PWM_DUTY;
                    m_writedata_d = duty_next;
                end else begin
                    // WAIT covers the I_eff-1 idle cycles between duty writes.
                    state_d = WAIT;
                    cnt_d   = intv_eff - 16'd2;
                end
            end
            WAIT: begin
                if (cnt_q == 16'd0) begin
                    state_d       = WR_STEP;
                    cur_duty_d    = duty_next;
                    m_write_d     = 1'b1;
                    m_address_d   = PWM_DUTY;
                    m_writedata_d = duty_next;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            WR_DIS: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                cur_duty_d = 32'd0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides whatever the sequencer planned, including a start.
        if (abort_req) begin
            state_d       = WR_DIS;
            busy_d        = busy_q;
            cur_duty_d    = 32'd0;
            complete      = 1'b0;
            start_accept  = 1'b0;
            m_write_d     = 1'b1;
            m_address_d   = PWM_CTRL;
            m_writedata_d = 32'd0;
        end
    end

    always_comb begin
        done_d = done_q;
        if (clear_req || start_accept) begin
            done_d = 1'b0;
        end
        if (complete) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            period_q      <= 32'd0;
            target_q      <= 32'd0;
            step_q        <= 32'd0;
            w_period_q    <= 32'd0;
            w_target_q    <= 32'd0;
            w_step_q      <= 16'd0;
            w_intv_q      <= 16'd0;
            cur_duty_q    <= 32'd0;
            cnt_q         <= 16'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= 2'd0;
            m_writedata_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            target_q      <= target_d;
            step_q        <= step_d;
            w_period_q    <= w_period_d;
            w_target_q    <= w_target_d;
            w_step_q      <= w_step_d;
            w_intv_q      <= w_intv_d;
            cur_duty_q    <= cur_duty_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
        end
    end

    assign m_write      = m_write_q;
    assign m_chipselect = m_write_q;
    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign m_byteenable = m_write_q ? 4'hF : 4'h0;
    assign busy         = busy_q;
    assign done_irq     = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: master writes are logged with cycle stamps
// and compared against a ramp schedule computed directly from PERIOD/TARGET/S/I.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_chipselect = 1'b0;
    logic [1:0]  s_address = 2'd0;
    logic        s_write = 1'b0;
    logic        s_read = 1'b0;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic        m_chipselect;
    logic        m_write;
    logic [1:0]  m_address;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        busy;
    logic        done_irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fall_cyc = -1;
    logic prev_busy = 1'b0;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t log_q[$];

    pwm_ramp_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_chipselect (s_chipselect),
        .s_address    (s_address),
        .s_write      (s_write),
        .s_read       (s_read),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_byteenable (m_byteenable),
        .busy         (busy),
        .done_irq     (done_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs every master write and checks the strobe relationships.
    always @(negedge clk) begin
        if (m_write === 1'b1) log_q.push_back('{m_address, m_writedata, cyc});
        total++;
        if (m_chipselect !== m_write || m_byteenable !== ((m_write === 1'b1) ? 4'hF : 4'h0)) begin
            bad++;
            $display("FAIL strobes: cs=%b wr=%b be=%h required cs=wr and be=F only when writing",
                     m_chipselect, m_write, m_byteenable);
        end
        if (prev_busy === 1'b1 && busy === 1'b0) fall_cyc = cyc;
        prev_busy = busy;
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge clk);
        s_chipselect = 1'b0; s_write = 1'b0; s_writedata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        #1 d = s_readdata;
        s_chipselect = 1'b0; s_read = 1'b0;
    endtask

    task automatic run_ramp(input logic [31:0] p, input logic [31:0] t, input logic [15:0] s,
                            input logic [15:0] iv, input bit disturb, input string tag);
        logic [1:0]  ea[$];
        logic [31:0] ed[$];
        int          eo[$];
        longint      d, se, ie, tt;
        int          off, n, m;
        logic [31:0] rdv;
        se = (s == 16'd0) ? 1 : longint'(s);
        ie = (iv == 16'd0) ? 1 : longint'(iv);
        tt = longint'(t);
        ea.push_back(2'd0); ed.push_back(p);     eo.push_back(0);
        ea.push_back(2'd1); ed.push_back(32'd0); eo.push_back(1);
        ea.push_back(2'd2); ed.push_back(32'd1); eo.push_back(2);
        d = 0; off = 2;
        while (d < tt) begin
            d = d + se;
            if (d > tt) d = tt;
            off = off + int'(ie);
            ea.push_back(2'd1); ed.push_back(d[31:0]); eo.push_back(off);
        end
        wr(2'd0, p); wr(2'd1, t); wr(2'd2, {iv, s});
        log_q.delete(); fall_cyc = -1;
        wr(2'd3, 32'h1);
        if (disturb) begin
            n = 0;
            while (log_q.size() < 4 && n < 200) begin @(negedge clk); #1; n++; end
            wr(2'd3, 32'h1); wr(2'd1, 32'd7); wr(2'd2, 32'h0001_0001);
            rd(2'd3, rdv);
            total++;
            if (rdv !== 32'h1) begin bad++; $display("FAIL %s ctrl_busy: got %h want 00000001", tag, rdv); end
        end
        n = 0;
        while (busy !== 1'b0 && n < off + 100) begin @(negedge clk); #1; n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s timeout: busy still %b", tag, busy); end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (log_q.size() != ea.size()) begin
            bad++; $display("FAIL %s write_count: got %0d want %0d", tag, log_q.size(), ea.size());
        end
        m = (log_q.size() < ea.size()) ? log_q.size() : ea.size();
        for (int k = 0; k < m; k++) begin
            total++;
            if (log_q[k].a !== ea[k] || log_q[k].d !== ed[k] || (log_q[k].c - log_q[0].c) != eo[k]) begin
                bad++;
                $display("FAIL %s write%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", tag, k,
                         log_q[k].a, log_q[k].d, log_q[k].c - log_q[0].c, ea[k], ed[k], eo[k]);
            end
        end
        if (log_q.size() > 0) begin
            total++;
            if (fall_cyc - log_q[0].c != off + 1) begin
                bad++; $display("FAIL %s busy_fall: got @%0d want @%0d", tag, fall_cyc - log_q[0].c, off + 1);
            end
        end
        total++;
        if (done_irq !== 1'b1) begin bad++; $display("FAIL %s done: got %b want 1", tag, done_irq); end
        $display("ramp %s P=%0d T=%0d S=%0d I=%0d writes=%0d", tag, p, t, s, iv, log_q.size());
    endtask

    task automatic test_reset();
        logic [31:0] rdv;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({m_chipselect, m_write, m_address, m_writedata, m_byteenable, busy, done_irq} !== '0) begin
            bad++; $display("FAIL reset_outputs: cs=%b wr=%b a=%0d d=%h be=%h busy=%b done=%b want all 0",
                            m_chipselect, m_write, m_address, m_writedata, m_byteenable, busy, done_irq);
        end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], rdv);
            total++;
            if (rdv !== 32'h0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", a, rdv); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_abort_idle();
        logic [31:0] rdv;
        log_q.delete();
        wr(2'd3, 32'h3);
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (log_q.size() != 1 || log_q[0].a !== 2'd2 || log_q[0].d !== 32'd0) begin
            bad++; $display("FAIL abort_idle: got %0d writes want exactly one (2,0)", log_q.size());
        end
        rd(2'd3, rdv);
        total++;
        if (rdv !== 32'h2) begin bad++; $display("FAIL abort_idle_ctrl: got %h want 00000002", rdv); end
        $display("abort in idle writes=%0d ctrl=%h", log_q.size(), rdv);
    endtask

    task automatic test_back_to_back_busy();
        logic [31:0] rdv;
        run_ramp(32'd999, 32'd500, 16'd100, 16'd10, 1'b1, "busy_start");
        rd(2'd3, rdv);
        total++;
        if (rdv !== 32'h2) begin bad++; $display("FAIL ctrl_done: got %h want 00000002", rdv); end
        wr(2'd3, 32'h4);
        rd(2'd3, rdv);
        total++;
        if (rdv !== 32'h0) begin bad++; $display("FAIL ctrl_clear: got %h want 00000000", rdv); end
        $display("clear done ctrl=%h", rdv);
    endtask

    task automatic test_abort();
        logic [31:0] rdv;
        int n;
        wr(2'd0, 32'd999); wr(2'd1, 32'd500); wr(2'd2, {16'd10, 16'd100});
        log_q.delete();
        wr(2'd3, 32'h1);
        n = 0;
        while (log_q.size() < 5 && n < 200) begin @(negedge clk); #1; n++; end
        wr(2'd3, 32'h2);
        repeat (30) @(negedge clk);
        #1;
        total++;
        if (log_q.size() != 6) begin bad++; $display("FAIL abort_count: got %0d want 6", log_q.size()); end
        else begin
            total++;
            if (log_q[5].a !== 2'd2 || log_q[5].d !== 32'd0 || log_q[4].d !== 32'd200) begin
                bad++; $display("FAIL abort_write: got (%0d,%0d) after %0d want (2,0) after 200",
                                log_q[5].a, log_q[5].d, log_q[4].d);
            end
        end
        rd(2'd3, rdv);
        total++;
        if (rdv !== 32'h0) begin bad++; $display("FAIL abort_ctrl: got %h want 00000000", rdv); end
        $display("abort mid ramp writes=%0d ctrl=%h", log_q.size(), rdv);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rdv;
        int n;
        wr(2'd0, 32'd999); wr(2'd1, 32'd500); wr(2'd2, {16'd10, 16'd100});
        log_q.delete();
        wr(2'd3, 32'h1);
        n = 0;
        while (log_q.size() < 4 && n < 200) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({m_chipselect, m_write, m_address, m_writedata, m_byteenable, busy, done_irq} !== '0) begin
            bad++; $display("FAIL reset_mid_outputs: wr=%b a=%0d d=%h busy=%b done=%b want all 0",
                            m_write, m_address, m_writedata, busy, done_irq);
        end
        rd(2'd1, rdv);
        total++;
        if (rdv !== 32'h0) begin bad++; $display("FAIL reset_mid_target: got %h want 0", rdv); end
        @(negedge clk);
        reset_n = 1'b1;
        log_q.delete();
        repeat (40) @(negedge clk);
        #1;
        total++;
        if (log_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_quiet: got %0d writes busy=%b want 0 writes busy=0", log_q.size(), busy);
        end
        $display("reset mid WAIT writes_after=%0d", log_q.size());
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            run_ramp($urandom, 32'($urandom_range(0, 300)), 16'($urandom_range(0, 120)),
                     16'($urandom_range(0, 4)), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        run_ramp(32'd999, 32'd500, 16'd100, 16'd10, 1'b0, "basic");
        run_ramp(32'd50, 32'd250, 16'd100, 16'd0, 1'b0, "saturate");
        run_ramp(32'd7, 32'd3, 16'd0, 16'd2, 1'b0, "min_step");
        run_ramp(32'd10, 32'd0, 16'd5, 16'd3, 1'b0, "zero_target");
        test_abort_idle();
        test_back_to_back_busy();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
